jstk_spi_responder: RTL and testbench

SPI-slave model of the joystick module that the `rocker` master polls. It answers 5-byte mode-0 transactions with programmable X/Y/button data and captures the LED command byte the master sends. It sits on the FPGA side of the SS/MOSI/SCLK/MISO pins, either in a loop-back harness or on a second board, so joystick-driven logic (cursor movement, 7-seg readout) can be exercised without the physical joystick.

---
 rtl/jstk_spi_responder.sv | 132 +++++++++++++
 tb/tb_jstk_spi_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave standing in for the joystick module.
// Returns 5-byte X/Y/button frames and captures the master's LED command.
module jstk_spi_responder #(
  parameter int SCLK_MIN_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] led,
  output logic       cmd_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  // SCLK levels shorter than two clk cycles cannot be resolved by the
  // synchronizer, so such a build never reports SCLK edges at all.
  localparam logic TRACK = (SCLK_MIN_HALF >= 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  ss_q;
  logic [2:0]  sclk_q;
  logic [1:0]  mosi_q;
  logic [38:0] tx;
  logic [6:0]  rx;
  logic [5:0]  bit_cnt;

  logic        ss_fall;
  logic        ss_rise;
  logic        sclk_rise;
  logic        sclk_fall;
  logic [7:0]  rx_next;
  logic [39:0] tx_frame;

  // Pin synchronizers keep running through reset, so an SS that is already
  // low at reset release looks steady and is not taken as a fresh fall.
  always_ff @(posedge clk) begin
    ss_q   <= {ss_q[1:0], SS};
    sclk_q <= {sclk_q[1:0], SCLK};
    mosi_q <= {mosi_q[0], MOSI};
  end

  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = TRACK & ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = TRACK & sclk_q[2] & ~sclk_q[1];
  assign rx_next   = {rx, mosi_q[1]};

  assign tx_frame = {
    x_pos[7:0], 6'b0, x_pos[9:8],
    y_pos[7:0], 6'b0, y_pos[9:8],
    5'b0, buttons
  };

  // Frame sequencing, shift registers and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tx         <= '0;
      rx         <= '0;
      bit_cnt    <= '0;
      MISO       <= 1'b0;
      led        <= 2'b00;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          MISO <= 1'b0;
          busy <= 1'b0;
          if (ss_fall) begin
            tx      <= tx_frame[38:0];
            MISO    <= tx_frame[39];
            rx      <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            MISO      <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            rx      <= rx_next[6:0];
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd7 && rx_next[7:2] == 6'b100000) begin
              led       <= rx_next[1:0];
              cmd_valid <= 1'b1;
            end
            if (bit_cnt == 6'd39) begin
              MISO  <= 1'b0;
              state <= DONE;
            end
          end else if (sclk_fall) begin
            MISO <= tx[38];
            tx   <= {tx[37:0], 1'b0};
          end
        end
        DONE: begin
          MISO <= 1'b0;
          if (ss_rise) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: bit-banged SPI master driving the responder,
// checked against a byte-level model of the joystick frame.
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SS = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic [2:0] buttons = '0;
  logic       MISO;
  logic [1:0] led;
  logic       cmd_valid;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;
  int cnt_cmd = 0;
  int cnt_done = 0;
  int cnt_err = 0;
  logic [1:0] led_model = 2'b00;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  b;
    logic [7:0]  cmd;
    int          half;
    logic [39:0] exp_miso;
    logic [1:0]  exp_led;
    int          exp_cmd;
  } vec_t;

  vec_t vt[4];

  always #5 clk = ~clk;

  jstk_spi_responder #(.SCLK_MIN_HALF(4)) dut (
    .clk(clk),
    .rst(rst),
    .SS(SS),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .MISO(MISO),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .buttons(buttons),
    .led(led),
    .cmd_valid(cmd_valid),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (cmd_valid) cnt_cmd <= cnt_cmd + 1;
    if (frame_done) cnt_done <= cnt_done + 1;
    if (frame_err) cnt_err <= cnt_err + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [39:0] ref_frame(input int x, input int y,
                                            input int b);
    int bytes[5];
    logic [39:0] f;
    f = '0;
    bytes = '{x % 256, x / 256, y % 256, y / 256, b};
    foreach (bytes[i]) f = (f << 8) | 40'(bytes[i]);
    return f;
  endfunction

  function automatic logic [1:0] ref_led(input logic [1:0] cur,
                                         input int cmd);
    return (cmd / 4 == 32) ? 2'(cmd % 4) : cur;
  endfunction

  task automatic shift_bits(input logic [39:0] mo, input int half,
                            input int nbits, output logic [39:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      got = {got[38:0], MISO};
      SCLK = 1'b1;
      repeat (half) @(negedge clk);
      SCLK = 1'b0;
      if (i < 39) MOSI = mo[38-i];
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [9:0] x, input logic [9:0] y,
                           input logic [2:0] b, input logic [39:0] mo,
                           input int half, input int nbits,
                           input bit late, input logic [9:0] x_late,
                           output logic [39:0] got);
    @(negedge clk);
    x_pos = x;
    y_pos = y;
    buttons = b;
    @(negedge clk);
    SS = 1'b0;
    MOSI = mo[39];
    if (late) begin
      for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
      check("busy_after_ss_fall", 64'(busy), 64'(1));
      @(negedge clk);
      x_pos = x_late;
    end
    repeat (half) @(negedge clk);
    shift_bits(mo, half, nbits, got);
  endtask

  task automatic end_frame();
    SS = 1'b1;
    MOSI = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic full_check(input string tag, input logic [9:0] x,
                            input logic [9:0] y, input logic [2:0] b,
                            input logic [7:0] cmd, input int half,
                            input bit late, input logic [9:0] x_late,
                            input logic [39:0] exp_miso,
                            input logic [1:0] exp_led, input int exp_cmd);
    int c0, d0, e0;
    logic [39:0] got;
    c0 = cnt_cmd;
    d0 = cnt_done;
    e0 = cnt_err;
    run_frame(x, y, b, {cmd, 32'($urandom)}, half, 40, late, x_late, got);
    check({tag, "_busy_in"}, 64'(busy), 64'(1));
    end_frame();
    check({tag, "_miso"}, 64'(got), 64'(exp_miso));
    check({tag, "_led"}, 64'(led), 64'(exp_led));
    check({tag, "_cmd_valid"}, 64'(cnt_cmd - c0), 64'(exp_cmd));
    check({tag, "_frame_done"}, 64'(cnt_done - d0), 64'(1));
    check({tag, "_frame_err"}, 64'(cnt_err - e0), 64'(0));
    check({tag, "_busy_out"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int c0, d0, e0;
    logic [39:0] got;
    logic [9:0]  rx_, ry_;
    logic [2:0]  rb_;
    logic [7:0]  rc_;
    logic [1:0]  el_;

    vt[0] = '{10'h2A5, 10'h15A, 3'b101, 8'h83, 25,
              40'hA5025A0105, 2'b11, 1};
    vt[1] = '{10'h2A5, 10'h15A, 3'b101, 8'h43, 7,
              40'hA5025A0105, 2'b11, 0};
    vt[2] = '{10'h3FF, 10'h000, 3'b111, 8'h80, 6,
              40'hFF03000007, 2'b00, 1};
    vt[3] = '{10'h001, 10'h3FE, 3'b000, 8'h82, 9,
              40'h0100FE0300, 2'b10, 1};

    // reset held with pins toggling
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check("rst_miso", 64'(MISO), 64'(0));
        check("rst_led", 64'(led), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pulses", 64'({cmd_valid, frame_done, frame_err}),
              64'(0));
      end
      SS = 1'($urandom);
      SCLK = 1'($urandom);
      MOSI = 1'($urandom);
    end
    SS = 1'b1;
    SCLK = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // table vectors
    for (int i = 0; i < 4; i++) begin
      full_check($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].b,
                 vt[i].cmd, vt[i].half, 1'b0, 10'h0, vt[i].exp_miso,
                 vt[i].exp_led, vt[i].exp_cmd);
      led_model = vt[i].exp_led;
    end

    // randomized frames against the byte-level model
    for (int i = 0; i < 10; i++) begin
      rx_ = 10'($urandom_range(0, 1023));
      ry_ = 10'($urandom_range(0, 1023));
      rb_ = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) rc_ = {6'b100000, 2'($urandom)};
      else rc_ = 8'($urandom);
      el_ = ref_led(led_model, int'(rc_));
      full_check($sformatf("rnd%0d", i), rx_, ry_, rb_, rc_,
                 $urandom_range(5, 10), 1'b0, 10'h0,
                 ref_frame(int'(rx_), int'(ry_), int'(rb_)), el_,
                 (int'(rc_) / 4 == 32) ? 1 : 0);
      led_model = el_;
    end

    // x_pos changes just after the frame has latched its inputs
    full_check("late_x", 10'h000, 10'h123, 3'b010, 8'h00, 6, 1'b1,
               10'h3FF, ref_frame(0, 'h123, 2), led_model, 0);
    full_check("after_late_x", 10'h3FF, 10'h123, 3'b010, 8'h00, 6,
               1'b0, 10'h0, ref_frame('h3FF, 'h123, 2), led_model, 0);

    // SS raised after 17 bits
    c0 = cnt_cmd;
    d0 = cnt_done;
    e0 = cnt_err;
    run_frame(10'h155, 10'h0AA, 3'b011, {8'h81, 32'($urandom)}, 6, 17,
              1'b0, 10'h0, got);
    end_frame();
    led_model = 2'b01;
    check("abort_err", 64'(cnt_err - e0), 64'(1));
    check("abort_done", 64'(cnt_done - d0), 64'(0));
    check("abort_cmd", 64'(cnt_cmd - c0), 64'(1));
    check("abort_led", 64'(led), 64'(led_model));
    check("abort_busy", 64'(busy), 64'(0));
    full_check("post_abort", 10'h2A5, 10'h15A, 3'b101, 8'h00, 6, 1'b0,
               10'h0, 40'hA5025A0105, led_model, 0);

    // reset in the middle of a frame, released with SS still low
    run_frame(10'h3C3, 10'h03C, 3'b110, {8'h83, 32'($urandom)}, 6, 20,
              1'b0, 10'h0, got);
    c0 = cnt_cmd;
    d0 = cnt_done;
    e0 = cnt_err;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_led", 64'(led), 64'(0));
    check("midrst_miso", 64'(MISO), 64'(0));
    rst = 1'b1;
    repeat (4) @(negedge clk);
    shift_bits({8'hFF, 32'hFFFF_FFFF}, 6, 4, got);
    check("midrst_idle_busy", 64'(busy), 64'(0));
    check("midrst_idle_miso", 64'(got[3:0]), 64'(0));
    end_frame();
    led_model = 2'b00;
    check("midrst_pulses",
          64'((cnt_cmd - c0) + (cnt_done - d0) + (cnt_err - e0)), 64'(0));
    full_check("post_rst", 10'h3C3, 10'h03C, 3'b110, 8'h81, 7, 1'b0,
               10'h0, ref_frame('h3C3, 'h03C, 6), 2'b01, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
